fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
- Controller in front of the FFT IP core. Programs the core's AXI-Stream config channel after reset and on request.
- Groups the free-running audio sample stream into FFT_SIZE-sample frames and gates frame starts on the enable input.
- Limits the number of frames in flight inside the core and reports dropped samples and completed frames to the rest of the synth.

Parameters:
- INPUT_WIDTH, 32, width of the signed audio sample.
- FFT_WIDTH, 16, width of the real and imaginary halves of the FFT input word.
- FFT_SIZE, 1024, samples per frame; must be a power of two.
- CFG_WIDTH, 16, width of the FFT config channel tdata.
- CFG_DEFAULT, 16'h0001, config word sent after reset (forward transform, default scaling).
- MAX_INFLIGHT, 2, maximum number of frames sent to the core whose results have not yet finished.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when high, new frames may start; when low, no new frame starts.
- cfg_word  in  CFG_WIDTH  config word latched when cfg_update is accepted.
- cfg_update  in  1  one-cycle request to re-send the config.
- audio_in  in  INPUT_WIDTH  signed audio sample.
- audio_valid  in  1  one-cycle strobe; samples have no backpressure.
- m_axis_config_tdata  out  CFG_WIDTH  FFT config word.
- m_axis_config_tvalid  out  1  config valid.
- m_axis_config_tready  in  1  config ready from the core.
- m_axis_data_tdata  out  2*FFT_WIDTH  {imag=0, real=scaled sample}.
- m_axis_data_tvalid  out  1  sample valid.
- m_axis_data_tlast  out  1  high on the last sample of a frame.
- m_axis_data_tready  in  1  ready from the core.
- fft_out_last  in  1  the core's output tvalid & tready & tlast (result frame finished).
- busy  out  1  high in any state except IDLE.
- overflow  out  1  one-cycle pulse when a sample is dropped.
- frame_done  out  1  one-cycle pulse per completed result frame.
- frames_inflight  out  $clog2(MAX_INFLIGHT+1)  count of outstanding frames.

Behaviour:
- Reset values: every output is 0. State is CONFIG. The pending config word is CFG_DEFAULT. Sample counter and in-flight counter are 0.
- Scaling: real = audio_in >>> (INPUT_WIDTH-FFT_WIDTH), arithmetic shift, truncated to FFT_WIDTH. Imaginary = 0.
- States:
  - CONFIG: hold tvalid high with the pending word until tvalid & tready. Then go to IDLE.
  - IDLE: go to CONFIG if a config update is pending. Otherwise go to FILL when enable=1 and frames_inflight < MAX_INFLIGHT.
  - FILL: stream samples. After the last sample handshakes, go to IDLE.
- Frame start alignment: a frame begins with the first audio_valid seen in FILL. Samples arriving while in IDLE or CONFIG are discarded silently, with no overflow pulse.
- Sample path (FILL only), latency 1 cycle:
  - audio_valid loads the output register and sets tvalid.
  - tvalid holds until the tvalid & tready handshake.
  - The sample counter advances on the handshake. tlast = (counter == FFT_SIZE-1) while tvalid.
  - If audio_valid arrives while tvalid=1 and tready=0, the new sample is dropped and overflow pulses. The held sample is kept and the counter does not advance.
  - If audio_valid arrives in the same cycle as a handshake, the new sample is loaded and no overflow occurs.
- tlast handshake: counter resets to 0, frames_inflight increments, state goes to IDLE.
- Enable deasserted mid-frame: the current frame completes. The next frame does not start.
- cfg_update:
  - Latches cfg_word as the pending word and sets a pending flag.
  - The update is applied only from IDLE, never mid-frame.
  - A second request before the update is applied overwrites the pending word.
- fft_out_last: frames_inflight decrements and frame_done pulses the same cycle.
  - Increment and decrement in the same cycle leave the count unchanged.
  - fft_out_last with a count of 0 is ignored; the count saturates at 0 and frame_done still pulses.
- Reset mid-frame: tvalid and tlast drop the next cycle, counters clear, and the core is reconfigured with CFG_DEFAULT.

Test Plan:
- Reset, then config tready=0 for 3 cycles, then 1 -> config tvalid high for 4 cycles with data 0x0001, one handshake, state goes to IDLE with busy=0.
- enable=1, tready=1, FFT_SIZE=8, audio_in=32'h00010000 strobed every 4 cycles -> 8 beats with tdata=32'h00000001, tlast only on beat 8, frames_inflight=1.
- audio_in=32'hFFFF0000 -> tdata real half = 16'hFFFF, imaginary half = 0.
- tready=0 across two audio_valid strobes -> exactly one overflow pulse, held sample unchanged, counter unchanged.
- MAX_INFLIGHT=2: two frames sent with no fft_out_last -> third frame not started (busy=0, samples ignored). Pulse fft_out_last -> frame_done, count goes to 1, FILL resumes.
- cfg_update with 0x00AB asserted mid-frame -> frame completes, then config handshake carries 0x00AB before the next FILL.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - FFT input framing, config sequencing and in-flight frame limiting
module fft_frame_scheduler #(
    parameter int                   INPUT_WIDTH  = 32,
    parameter int                   FFT_WIDTH    = 16,
    parameter int                   FFT_SIZE     = 1024,
    parameter int                   CFG_WIDTH    = 16,
    parameter logic [CFG_WIDTH-1:0] CFG_DEFAULT  = 16'h0001,
    parameter int                   MAX_INFLIGHT = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [CFG_WIDTH-1:0]               cfg_word,
    input  logic                               cfg_update,
    input  logic [INPUT_WIDTH-1:0]             audio_in,
    input  logic                               audio_valid,
    output logic [CFG_WIDTH-1:0]               m_axis_config_tdata,
    output logic                               m_axis_config_tvalid,
    input  logic                               m_axis_config_tready,
    output logic [2*FFT_WIDTH-1:0]             m_axis_data_tdata,
    output logic                               m_axis_data_tvalid,
    output logic                               m_axis_data_tlast,
    input  logic                               m_axis_data_tready,
    input  logic                               fft_out_last,
    output logic                               busy,
    output logic                               overflow,
    output logic                               frame_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  frames_inflight
);

    localparam int SHIFT = INPUT_WIDTH - FFT_WIDTH;
    localparam int CNT_W = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);
    localparam logic [IF_W-1:0]  IF_MAX   = IF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_CONFIG = 2'd0,
        S_IDLE   = 2'd1,
        S_FILL   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CFG_WIDTH-1:0]   cfg_pend;
    logic                   cfg_pend_flag;
    logic [CNT_W-1:0]       sample_cnt;
    logic                   cfg_hs;
    logic                   data_hs;
    logic                   frame_hs;
    logic                   dec_ok;
    logic [FFT_WIDTH-1:0]   real_part;

    assign cfg_hs            = m_axis_config_tvalid & m_axis_config_tready;
    assign data_hs           = m_axis_data_tvalid & m_axis_data_tready;
    assign m_axis_data_tlast = m_axis_data_tvalid && (sample_cnt == LAST_IDX);
    assign frame_hs          = data_hs & m_axis_data_tlast;
    assign dec_ok            = fft_out_last && (frames_inflight != '0);
    assign real_part         = FFT_WIDTH'($signed(audio_in) >>> SHIFT);

    // Next-state: config only from IDLE, frames start only with room in the core
    always_comb begin
        state_next = state;
        case (state)
            S_CONFIG: begin
                if (cfg_hs) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (cfg_pend_flag)
                    state_next = S_CONFIG;
                else if (enable && (frames_inflight < IF_MAX))
                    state_next = S_FILL;
            end
            S_FILL: begin
                if (frame_hs) state_next = S_IDLE;
            end
            default: state_next = S_CONFIG;
        endcase
    end

    // State register; busy is registered alongside so it is 0 while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CONFIG;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    // Config channel: word is captured on entry to CONFIG so it is stable during the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_pend             <= CFG_DEFAULT;
            cfg_pend_flag        <= 1'b0;
            m_axis_config_tdata  <= '0;
            m_axis_config_tvalid <= 1'b0;
        end else begin
            if (state == S_CONFIG && !m_axis_config_tvalid) begin
                m_axis_config_tdata  <= cfg_pend;
                m_axis_config_tvalid <= 1'b1;
                cfg_pend_flag        <= 1'b0;
            end else if (cfg_hs) begin
                m_axis_config_tvalid <= 1'b0;
            end
            // A request arriving while the previous word is consumed stays pending
            if (cfg_update) begin
                cfg_pend      <= cfg_word;
                cfg_pend_flag <= 1'b1;
            end
        end
    end

    // Sample path: one-deep output register, drop-and-flag when the core stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
            sample_cnt         <= '0;
            overflow           <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (state == S_FILL) begin
                if (data_hs)
                    sample_cnt <= frame_hs ? '0 : sample_cnt + 1'b1;
                // A sample coinciding with the frame's final handshake belongs to no frame
                if (audio_valid && !frame_hs && (!m_axis_data_tvalid || data_hs)) begin
                    m_axis_data_tdata  <= {{FFT_WIDTH{1'b0}}, real_part};
                    m_axis_data_tvalid <= 1'b1;
                end else if (data_hs) begin
                    m_axis_data_tvalid <= 1'b0;
                end
                if (audio_valid && m_axis_data_tvalid && !m_axis_data_tready)
                    overflow <= 1'b1;
            end
        end
    end

    // In-flight accounting: sent frames minus finished results, floored at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_inflight <= '0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= fft_out_last;
            if (frame_hs && !dec_ok)
                frames_inflight <= frames_inflight + 1'b1;
            else if (!frame_hs && dec_ok)
                frames_inflight <= frames_inflight - 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed bench with frame-level scoreboard for fft_frame_scheduler
module tb_fft_frame_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] cfg_word = 16'h0;
    logic        cfg_update = 1'b0;
    logic [31:0] audio_in = 32'h0;
    logic        audio_valid = 1'b0;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready = 1'b0;
    logic [31:0] d_tdata;
    logic        d_tvalid;
    logic        d_tlast;
    logic        d_tready = 1'b0;
    logic        fol = 1'b0;
    logic        busy;
    logic        overflow;
    logic        frame_done;
    logic [1:0]  frames_inflight;

    fft_frame_scheduler #(
        .INPUT_WIDTH (32),
        .FFT_WIDTH   (16),
        .FFT_SIZE    (N),
        .CFG_WIDTH   (16),
        .CFG_DEFAULT (16'h0001),
        .MAX_INFLIGHT(2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .cfg_word            (cfg_word),
        .cfg_update          (cfg_update),
        .audio_in            (audio_in),
        .audio_valid         (audio_valid),
        .m_axis_config_tdata (cfg_tdata),
        .m_axis_config_tvalid(cfg_tvalid),
        .m_axis_config_tready(cfg_tready),
        .m_axis_data_tdata   (d_tdata),
        .m_axis_data_tvalid  (d_tvalid),
        .m_axis_data_tlast   (d_tlast),
        .m_axis_data_tready  (d_tready),
        .fft_out_last        (fol),
        .busy                (busy),
        .overflow            (overflow),
        .frame_done          (frame_done),
        .frames_inflight     (frames_inflight)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          beat = 0;
    int          model_if = 0;
    logic        prev_fol = 1'b0;
    int          ovf_total = 0;
    int          cfg_hs_n = 0;
    int          beats_since = 0;
    int          cfg_beats = 0;
    logic [15:0] cfg_last = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input bit keep, input logic [31:0] e);
        audio_in    = v;
        audio_valid = 1'b1;
        if (keep) exp_q.push_back(e);
        tick();
        audio_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Scoreboard: frame grouping, sample order, in-flight count and frame_done pulses
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat        = 0;
            model_if    = 0;
            prev_fol    = 1'b0;
            beats_since = 0;
        end else begin
            chk("frames_inflight", frames_inflight, model_if);
            chk("frame_done", frame_done, prev_fol);
            if (overflow) ovf_total++;
            if (d_tvalid) chk("imag_zero", d_tdata[31:16], 16'h0);
            if (cfg_tvalid && cfg_tready) begin
                cfg_hs_n++;
                cfg_last  = cfg_tdata;
                cfg_beats = beats_since;
            end
            if (fol && model_if > 0) model_if--;
            if (d_tvalid && d_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", d_tdata, 64'hdead);
                end else begin
                    chk("beat_data", d_tdata, exp_q.pop_front());
                end
                chk("beat_tlast", d_tlast, (beat == N - 1));
                beats_since++;
                if (beat == N - 1) begin
                    beat        = 0;
                    beats_since = 0;
                    model_if++;
                end else begin
                    beat++;
                end
            end
            prev_fol = fol;
        end
    end

    logic [31:0] vin  [8] = '{32'hFFFF0000, 32'h7FFF8000, 32'h80000000, 32'h12345678,
                              32'h0000FFFF, 32'hFFFFFFFF, 32'h00018000, 32'hFFFE0001};
    logic [31:0] vexp [8] = '{32'h0000FFFF, 32'h00007FFF, 32'h00008000, 32'h00001234,
                              32'h00000000, 32'h0000FFFF, 32'h00000001, 32'h0000FFFE};

    initial begin
        int hi;
        bit done;
        int ovf0;
        int n0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_cfg_tvalid", cfg_tvalid, 0);
        chk("rst_cfg_tdata", cfg_tdata, 0);
        chk("rst_d_tvalid", d_tvalid, 0);
        chk("rst_d_tdata", d_tdata, 0);
        chk("rst_d_tlast", d_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_inflight", frames_inflight, 0);
        tick();
        rst = 1'b0;

        // Default config held through three stalled cycles, then accepted
        hi = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cfg_tvalid) begin
                hi++;
                if (hi == 1) chk("cfg_default_data", cfg_tdata, 16'h0001);
            end else if (hi > 0) begin
                done = 1'b1;
            end
            tick();
            if (hi == 3) cfg_tready = 1'b1;
        end
        chk("cfg_reset_done", done, 1);
        chk("cfg_tvalid_cycles", hi, 4);
        chk("cfg_handshakes", cfg_hs_n, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        tick();

        // Result-finished with nothing outstanding: pulse but no underflow
        fol = 1'b1;
        tick();
        fol = 1'b0;
        @(negedge clk);
        chk("sat_frame_done", frame_done, 1);
        chk("sat_inflight", frames_inflight, 0);
        tick();

        // Frame 1: constant sample, one per four cycles
        enable   = 1'b1;
        d_tready = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < N; i++) send(32'h00010000, 1'b1, 32'h00000001);
        @(negedge clk);
        chk("f1_inflight", frames_inflight, 1);
        chk("f1_drained", exp_q.size(), 0);
        tick();

        // Frame 2: scaling vectors, with a stall that drops one sample
        for (int i = 0; i < N; i++) begin
            if (i == 2) begin
                d_tready = 1'b0;
                send(vin[i], 1'b1, vexp[i]);
                ovf0        = ovf_total;
                audio_in    = 32'h11110000;
                audio_valid = 1'b1;
                tick();
                audio_valid = 1'b0;
                repeat (2) tick();
                @(negedge clk);
                chk("stall_overflow_pulses", ovf_total - ovf0, 1);
                chk("stall_held_data", d_tdata, 32'h00008000);
                chk("stall_held_valid", d_tvalid, 1);
                tick();
                d_tready = 1'b1;
                repeat (3) tick();
            end else begin
                send(vin[i], 1'b1, vexp[i]);
            end
        end

        // Two frames outstanding: no third frame, samples ignored
        repeat (3) tick();
        @(negedge clk);
        chk("blocked_busy", busy, 0);
        chk("blocked_inflight", frames_inflight, 2);
        tick();
        send(32'h00050000, 1'b0, 32'h0);
        @(negedge clk);
        chk("blocked_busy2", busy, 0);
        chk("blocked_no_data", d_tvalid, 0);
        tick();
        fol = 1'b1;
        tick();
        fol = 1'b0;
        @(negedge clk);
        chk("release_frame_done", frame_done, 1);
        chk("release_inflight", frames_inflight, 1);
        tick();
        repeat (2) tick();
        @(negedge clk);
        chk("resume_busy", busy, 1);
        tick();

        // Frame 3: config request mid-frame is deferred until the frame ends
        n0 = cfg_hs_n;
        for (int i = 0; i < N; i++) begin
            if (i == 3) begin
                cfg_word   = 16'h00AB;
                cfg_update = 1'b1;
                tick();
                cfg_update = 1'b0;
                fol = 1'b1;
                tick();
                fol = 1'b0;
            end
            send(32'h00200000 + (32'(i) << 16), 1'b1, 32'h00000020 + 32'(i));
        end
        for (int i = 0; i < 40 && cfg_hs_n == n0; i++) tick();
        chk("cfg_update_count", cfg_hs_n, n0 + 1);
        chk("cfg_update_data", cfg_last, 16'h00AB);
        chk("cfg_update_after_frame", cfg_beats, 0);

        // Frame 4: hold the last beat, then reset mid-frame
        repeat (3) tick();
        for (int i = 0; i < N - 1; i++)
            send(32'h00300000 + (32'(i) << 16), 1'b1, 32'h00000030 + 32'(i));
        d_tready = 1'b0;
        send(32'h00370000, 1'b1, 32'h00000037);
        @(negedge clk);
        chk("held_last_valid", d_tvalid, 1);
        chk("held_last_tlast", d_tlast, 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_tvalid", d_tvalid, 0);
        chk("midrst_tlast", d_tlast, 0);
        chk("midrst_inflight", frames_inflight, 0);
        tick();
        rst      = 1'b0;
        d_tready = 1'b1;
        n0 = cfg_hs_n;
        for (int i = 0; i < 40 && cfg_hs_n == n0; i++) tick();
        chk("reconfig_count", cfg_hs_n, n0 + 1);
        chk("reconfig_data", cfg_last, 16'h0001);
        chk("overflow_total", ovf_total, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
